// File: rtl/wrra_weight_ctrl_if.sv
// Allocator-side bundle for the WRRA weight controller: grant/tail inputs,
// configured weights, weight-consumed outputs and the debug trigger/trace pair.
interface wrra_weight_ctrl_if #(
    parameter int P       = 5,
    parameter int V       = 4,
    parameter int WEIGHTw = 4
);
    logic [P*WEIGHTw-1:0] iport_weight_all;
    logic [P*V-1:0]       ivc_num_getting_sw_grant;
    logic [P-1:0]         any_ivc_sw_request_granted_all;
    logic [P*V-1:0]       flit_is_tail_all;
    logic [P-1:0]         iport_weight_is_consumed_all;
    logic [P*V-1:0]       vc_weight_is_consumed_all;
    logic                 trigger;
    logic [31:0]          trace;

    modport master (
        output iport_weight_all, ivc_num_getting_sw_grant,
               any_ivc_sw_request_granted_all, flit_is_tail_all,
        input  iport_weight_is_consumed_all, vc_weight_is_consumed_all,
               trigger, trace
    );

    modport slave (
        input  iport_weight_all, ivc_num_getting_sw_grant,
               any_ivc_sw_request_granted_all, flit_is_tail_all,
        output iport_weight_is_consumed_all, vc_weight_is_consumed_all,
               trigger, trace
    );
endinterface

// File: rtl/wrra_weight_ctrl.sv
// Per-input-port WRRA weight scheduler: counts switch grants against the port
// weight and defers rotation to packet tails. Optional checker: WRRA_WEIGHT_DEBUG_EN.
module wrra_weight_ctrl #(
    parameter int V       = 4,
    parameter int P       = 5,
    parameter int WEIGHTw = 4
) (
    input  logic             clk,
    input  logic             reset,
    wrra_weight_ctrl_if.slave bus
);

    typedef enum logic {ACTIVE = 1'b0, DRAIN = 1'b1} vc_state_e;

    vc_state_e            state_q [P*V];
    vc_state_e            state_d [P*V];
    logic [WEIGHTw-1:0]   cnt_q   [P];
    logic [WEIGHTw-1:0]   cnt_d   [P];
    logic [P-1:0]         flag_q, flag_d;
    logic [P-1:0]         flag_set;
    logic [P-1:0]         drain;
    logic [P*V-1:0]       grant;
    logic [P*V-1:0]       pulse_q, pulse_d;
    logic [WEIGHTw-1:0]   eff_w;

    function automatic logic [WEIGHTw-1:0] eff_weight(input logic [WEIGHTw-1:0] w);
        return (w == '0) ? WEIGHTw'(1) : w;
    endfunction

    always_comb begin
        grant = '0;
        drain = '0;
        for (int i = 0; i < P; i++) begin
            for (int j = 0; j < V; j++) begin
                grant[i*V+j] = bus.any_ivc_sw_request_granted_all[i] &
                               bus.ivc_num_getting_sw_grant[i*V+j];
                if (state_q[i*V+j] == DRAIN) drain[i] = 1'b1;
            end
        end
    end

    // Port counters: frozen while a VC drains its packet, so the round cannot roll over mid-packet.
    always_comb begin
        eff_w    = '0;
        flag_d   = flag_q;
        flag_set = '0;
        for (int i = 0; i < P; i++) begin
            cnt_d[i] = cnt_q[i];
            eff_w    = eff_weight(bus.iport_weight_all[i*WEIGHTw +: WEIGHTw]);
            if (drain[i]) begin
                flag_d[i] = 1'b1;
            end else if (bus.any_ivc_sw_request_granted_all[i]) begin
                if (flag_q[i]) begin
                    cnt_d[i]  = eff_w - WEIGHTw'(1);
                    flag_d[i] = (eff_w == WEIGHTw'(1));
                end else begin
                    cnt_d[i]  = cnt_q[i] - WEIGHTw'(1);
                    flag_d[i] = (cnt_q[i] == WEIGHTw'(1));
                end
                flag_set[i] = flag_d[i];
            end
        end
    end

    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < P; i++) begin
            for (int j = 0; j < V; j++) begin
                state_d[i*V+j] = state_q[i*V+j];
                case (state_q[i*V+j])
                    ACTIVE: begin
                        if (grant[i*V+j] && flag_set[i]) begin
                            if (bus.flit_is_tail_all[i*V+j]) pulse_d[i*V+j] = 1'b1;
                            else                             state_d[i*V+j] = DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (grant[i*V+j] && bus.flit_is_tail_all[i*V+j]) begin
                            pulse_d[i*V+j] = 1'b1;
                            state_d[i*V+j] = ACTIVE;
                        end
                    end
                    default: state_d[i*V+j] = ACTIVE;
                endcase
            end
        end
    end

    // Flag resets to 1 so the very first grant after reset performs a reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < P; i++) cnt_q[i] <= '0;
            for (int k = 0; k < P*V; k++) state_q[k] <= ACTIVE;
            flag_q  <= '1;
            pulse_q <= '0;
        end else begin
            for (int i = 0; i < P; i++) cnt_q[i] <= cnt_d[i];
            for (int k = 0; k < P*V; k++) state_q[k] <= state_d[k];
            flag_q  <= flag_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.iport_weight_is_consumed_all = flag_q;
    assign bus.vc_weight_is_consumed_all    = pulse_q;

`ifdef WRRA_WEIGHT_DEBUG_EN
    logic [15:0]  cycle_q, cycle_d;
    logic         trigger_q, trigger_d;
    logic [31:0]  trace_q, trace_d;
    logic         viol_found;
    logic [7:0]   viol_port, viol_code;
    logic [V-1:0] port_bits;

    // Scan from the top port down so the lowest violating port is the one kept.
    always_comb begin
        viol_found = 1'b0;
        viol_port  = '0;
        viol_code  = '0;
        port_bits  = '0;
        for (int i = P-1; i >= 0; i--) begin
            port_bits = bus.ivc_num_getting_sw_grant[i*V +: V];
            if ((port_bits & (port_bits - V'(1))) != '0) begin
                viol_found = 1'b1;
                viol_port  = 8'(i);
                viol_code  = 8'h01;
            end else if ((port_bits != '0) && !bus.any_ivc_sw_request_granted_all[i]) begin
                viol_found = 1'b1;
                viol_port  = 8'(i);
                viol_code  = 8'h02;
            end
        end
    end

    always_comb begin
        cycle_d   = cycle_q + 16'd1;
        trigger_d = trigger_q;
        trace_d   = trace_q;
        if (viol_found && !trigger_q) begin
            trigger_d = 1'b1;
            trace_d   = {viol_port, viol_code, cycle_q};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q   <= '0;
            trigger_q <= 1'b0;
            trace_q   <= '0;
        end else begin
            cycle_q   <= cycle_d;
            trigger_q <= trigger_d;
            trace_q   <= trace_d;
        end
    end

    assign bus.trigger = trigger_q;
    assign bus.trace   = trace_q;
`else
    assign bus.trigger = 1'b0;
    assign bus.trace   = '0;
`endif

endmodule

// File: tb/tb_wrra_weight_ctrl.sv
// Directed-vector bench for wrra_weight_ctrl: a state-carrying vector table
// plus hand-written drain, weight-change, async-reset and debug sequences.
module tb_wrra_weight_ctrl;
    localparam int P       = 5;
    localparam int V       = 4;
    localparam int WEIGHTw = 4;
    localparam logic [P*WEIGHTw-1:0] WEIGHTS = 20'h14023; // p4=1 p3=4 p2=0 p1=2 p0=3

    typedef struct {
        logic [P-1:0]   any;
        logic [P*V-1:0] ivc;
        logic [P*V-1:0] tail;
        logic [P-1:0]   exp_iport;
        logic [P*V-1:0] exp_vc;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;
    vec_t tbl [15];

    wrra_weight_ctrl_if #(.P(P), .V(V), .WEIGHTw(WEIGHTw)) bus ();

    wrra_weight_ctrl #(.V(V), .P(P), .WEIGHTw(WEIGHTw)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [P-1:0] ei, input logic [P*V-1:0] ev);
        nvec++;
        if (bus.iport_weight_is_consumed_all !== ei || bus.vc_weight_is_consumed_all !== ev) begin
            nerr++;
            $display("FAIL %s: iport=%h vc=%h, expected iport=%h vc=%h", name,
                     bus.iport_weight_is_consumed_all, bus.vc_weight_is_consumed_all, ei, ev);
        end
    endtask

    task automatic check_dbg(input string name, input logic et, input logic [31:0] etr);
        nvec++;
        if (bus.trigger !== et || bus.trace !== etr) begin
            nerr++;
            $display("FAIL %s: trigger=%b trace=%h, expected trigger=%b trace=%h", name,
                     bus.trigger, bus.trace, et, etr);
        end
    endtask

    // Applies inputs for one clock; returns at the following negedge.
    task automatic drive(input logic [P-1:0] any, input logic [P*V-1:0] ivc, input logic [P*V-1:0] tail);
        bus.any_ivc_sw_request_granted_all = any;
        bus.ivc_num_getting_sw_grant       = ivc;
        bus.flit_is_tail_all               = tail;
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.any_ivc_sw_request_granted_all = '0;
        bus.ivc_num_getting_sw_grant       = '0;
        bus.flit_is_tail_all               = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{5'h01, 20'h00001, 20'h00000, 5'h1E, 20'h00000};
        tbl[1]  = '{5'h01, 20'h00001, 20'h00000, 5'h1E, 20'h00000};
        tbl[2]  = '{5'h01, 20'h00001, 20'h00000, 5'h1F, 20'h00000};
        tbl[3]  = '{5'h00, 20'h00000, 20'h00000, 5'h1F, 20'h00000};
        tbl[4]  = '{5'h00, 20'h00000, 20'h00000, 5'h1F, 20'h00000};
        tbl[5]  = '{5'h01, 20'h00001, 20'h00001, 5'h1F, 20'h00001};
        tbl[6]  = '{5'h00, 20'h00000, 20'h00000, 5'h1F, 20'h00000};
        tbl[7]  = '{5'h01, 20'h00001, 20'h00001, 5'h1E, 20'h00000};
        tbl[8]  = '{5'h04, 20'h00200, 20'h00200, 5'h1E, 20'h00200};
        tbl[9]  = '{5'h04, 20'h00200, 20'h00200, 5'h1E, 20'h00200};
        tbl[10] = '{5'h04, 20'h00200, 20'h00200, 5'h1E, 20'h00200};
        tbl[11] = '{5'h00, 20'h00000, 20'h00000, 5'h1E, 20'h00000};
        tbl[12] = '{5'h01, 20'h00000, 20'h00000, 5'h1E, 20'h00000};
        tbl[13] = '{5'h01, 20'h00000, 20'h00000, 5'h1F, 20'h00000};
        tbl[14] = '{5'h01, 20'h00001, 20'h00001, 5'h1E, 20'h00000};

        bus.iport_weight_all = WEIGHTS;
        reset = 1'b1;
        bus.any_ivc_sw_request_granted_all = '0;
        bus.ivc_num_getting_sw_grant       = '0;
        bus.flit_is_tail_all               = '0;
        @(negedge clk);
        check("reset_state", 5'h1F, 20'h0);
        check_dbg("reset_dbg", 1'b0, 32'h0);
        reset = 1'b0;

        for (int k = 0; k < 15; k++) begin
            drive(tbl[k].any, tbl[k].ivc, tbl[k].tail);
            check($sformatf("table_%0d", k), tbl[k].exp_iport, tbl[k].exp_vc);
        end

        // Port1 weight 2: VC0 drains while VC2 is granted; counter must stay frozen.
        do_reset();
        drive(5'h02, 20'h00010, 20'h0);
        check("p1_first", 5'h1D, 20'h0);
        drive(5'h02, 20'h00010, 20'h0);
        check("p1_drain_enter", 5'h1F, 20'h0);
        for (int k = 0; k < 5; k++) begin
            drive(5'h02, 20'h00040, 20'h00040);
            check($sformatf("p1_vc2_frozen_%0d", k), 5'h1F, 20'h0);
        end
        drive(5'h02, 20'h00010, 20'h00010);
        check("p1_vc0_tail", 5'h1F, 20'h00010);
        drive(5'h02, 20'h00040, 20'h0);
        check("p1_reload", 5'h1D, 20'h0);
        drive(5'h02, 20'h00040, 20'h0);
        check("p1_reload_cnt1", 5'h1F, 20'h0);

        // Port3 weight 4 -> 2 after the first grant of the round.
        do_reset();
        drive(5'h08, 20'h01000, 20'h01000);
        check("p3_g1", 5'h17, 20'h0);
        bus.iport_weight_all = 20'h12023;
        drive(5'h08, 20'h01000, 20'h01000);
        check("p3_g2", 5'h17, 20'h0);
        drive(5'h08, 20'h01000, 20'h01000);
        check("p3_g3", 5'h17, 20'h0);
        drive(5'h08, 20'h01000, 20'h01000);
        check("p3_g4", 5'h1F, 20'h01000);
        drive(5'h08, 20'h01000, 20'h01000);
        check("p3_r2_g1", 5'h17, 20'h0);
        drive(5'h08, 20'h01000, 20'h01000);
        check("p3_r2_g2", 5'h1F, 20'h01000);
        bus.iport_weight_all = WEIGHTS;

        // Asynchronous reset with port0 draining, port1 mid-round and a port2 pulse pending.
        do_reset();
        drive(5'h01, 20'h00001, 20'h0);
        drive(5'h01, 20'h00001, 20'h0);
        drive(5'h07, 20'h00211, 20'h00200);
        check("pre_async_reset", 5'h1D, 20'h00200);
        bus.any_ivc_sw_request_granted_all = '0;
        bus.ivc_num_getting_sw_grant       = '0;
        bus.flit_is_tail_all               = '0;
        reset = 1'b1;
        #1;
        check("async_reset", 5'h1F, 20'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(5'h01, 20'h00001, 20'h00001);
        check("post_reset_tail", 5'h1E, 20'h0);
        check_dbg("dbg_idle", 1'b0, 32'h0);

`ifdef WRRA_WEIGHT_DEBUG_EN
        do_reset();
        for (int k = 0; k < 10; k++) drive(5'h00, 20'h0, 20'h0);
        drive(5'h10, 20'h30000, 20'h0);
        check_dbg("dbg_first_viol", 1'b1, 32'h0401_000A);
        drive(5'h00, 20'h00001, 20'h0);
        check_dbg("dbg_sticky", 1'b1, 32'h0401_000A);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
